// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, RAM port and control bundle for mem_arbiter
interface mem_arbiter_if;
    logic        rdy_in;
    logic        clear;
    logic        io_buffer_full;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport master (
        input  rdy_in, clear, io_buffer_full,
        input  inst_req, inst_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
        output inst_valid, inst_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport slave (
        output rdy_in, clear, io_buffer_full,
        output inst_req, inst_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
        input  inst_valid, inst_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port byte RAM arbiter for icache fetches and LSB loads/stores
module mem_arbiter (
    input  logic           clk_in,
    input  logic           rst_in,
    mem_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [2:0]  n_q, n_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        last_ls_q, last_ls_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] a_q, a_d;
    logic [7:0]  dout_q, dout_d;
    logic        wr_q, wr_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        io_stall;
    logic        fetch_cand;
    logic        ls_cand;
    logic [2:0]  ls_n;
    logic [2:0]  k_inc;
    logic [1:0]  cap_idx;
    logic [31:0] a_next;

    // A store to the UART window waits while its buffer is full; clear only kills speculative reads.
    assign io_stall   = bus.ls_we && (bus.ls_addr[17:16] == 2'b11) && bus.io_buffer_full;
    assign fetch_cand = bus.inst_req && !bus.clear;
    assign ls_cand    = bus.ls_req && !io_stall && (bus.ls_we || !bus.clear);
    assign ls_n       = (bus.ls_size == 2'd0) ? 3'd1 : (bus.ls_size == 2'd1) ? 3'd2 : 3'd4;
    assign k_inc      = k_q + 3'd1;
    assign cap_idx    = k_q[1:0] - 2'd1;
    assign a_next     = addr_q + {29'd0, k_inc};

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        n_d          = n_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_ls_d    = last_ls_q;
        buf_d        = buf_q;
        a_d          = a_q;
        dout_d       = dout_q;
        wr_d         = wr_q;
        inst_valid_d = 1'b0;
        inst_data_d  = inst_data_q;
        ls_done_d    = 1'b0;
        ls_rdata_d   = ls_rdata_q;
        case (state_q)
            IDLE: begin
                if (fetch_cand && (!ls_cand || last_ls_q)) begin
                    state_d   = FETCH;
                    last_ls_d = 1'b0;
                    addr_d    = bus.inst_addr;
                    n_d       = 3'd4;
                    k_d       = 3'd0;
                    a_d       = bus.inst_addr;
                    buf_d     = 32'd0;
                end else if (ls_cand) begin
                    last_ls_d = 1'b1;
                    addr_d    = bus.ls_addr;
                    wdata_d   = bus.ls_wdata;
                    n_d       = ls_n;
                    k_d       = 3'd0;
                    a_d       = bus.ls_addr;
                    buf_d     = 32'd0;
                    if (bus.ls_we) begin
                        state_d = STORE;
                        dout_d  = bus.ls_wdata[7:0];
                        wr_d    = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            FETCH, LOAD: begin
                if (bus.clear) begin
                    state_d = IDLE;
                    k_d     = 3'd0;
                    a_d     = 32'd0;
                end else begin
                    // Byte k-1 arrives on mem_din while address k is presented.
                    if (k_q != 3'd0) begin
                        buf_d[{cap_idx, 3'b000} +: 8] = bus.mem_din;
                    end
                    a_d = (k_inc < n_q) ? a_next : 32'd0;
                    k_d = k_inc;
                    if (k_q == n_q) begin
                        state_d = IDLE;
                        k_d     = 3'd0;
                        if (state_q == FETCH) begin
                            inst_valid_d = 1'b1;
                            inst_data_d  = buf_d;
                        end else begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = buf_d;
                        end
                    end
                end
            end
            STORE: begin
                if (k_inc < n_q) begin
                    k_d    = k_inc;
                    a_d    = a_next;
                    dout_d = wdata_q[{k_inc[1:0], 3'b000} +: 8];
                end else begin
                    state_d   = IDLE;
                    k_d       = 3'd0;
                    a_d       = 32'd0;
                    dout_d    = 8'd0;
                    wr_d      = 1'b0;
                    ls_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            k_q          <= 3'd0;
            n_q          <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            last_ls_q    <= 1'b1;
            buf_q        <= 32'd0;
            a_q          <= 32'd0;
            dout_q       <= 8'd0;
            wr_q         <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= 32'd0;
            ls_done_q    <= 1'b0;
            ls_rdata_q   <= 32'd0;
        end else if (bus.rdy_in) begin
            state_q      <= state_d;
            k_q          <= k_d;
            n_q          <= n_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_ls_q    <= last_ls_d;
            buf_q        <= buf_d;
            a_q          <= a_d;
            dout_q       <= dout_d;
            wr_q         <= wr_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            ls_done_q    <= ls_done_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    assign bus.mem_a      = a_q;
    assign bus.mem_dout   = dout_q;
    assign bus.mem_wr     = wr_q && bus.rdy_in;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_data  = inst_data_q;
    assign bus.ls_done    = ls_done_q;
    assign bus.ls_rdata   = ls_rdata_q;
endmodule
